// File: rtl/mem_seq_if.sv
// Bus bundle between a requester/memory pair and the mem_seq sequencer.
//   req_*      : request channel (valid/ready), write or read
//   rsp_*      : in-order read response channel (valid/ready)
//   clear/busy : zero-fill request and fill-in-progress flag
//   mem_*      : port to the 16x8 synchronous-read memory
// master : requester + memory side (drives requests, rsp_ready, clear, mem_dat_r)
// slave  : the sequencer
interface mem_seq_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_adr;
    logic [DATA_W-1:0] req_dat;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_dat;
    logic              clear;
    logic              busy;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_dat_w;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dat_r;

    modport master (
        output req_valid, req_we, req_adr, req_dat, rsp_ready, clear, mem_dat_r,
        input  req_ready, rsp_valid, rsp_dat, busy, mem_adr, mem_dat_w, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_adr, req_dat, rsp_ready, clear, mem_dat_r,
        output req_ready, rsp_valid, rsp_dat, busy, mem_adr, mem_dat_w, mem_we
    );
endinterface

// File: rtl/mem_seq.sv
// mem_seq: request sequencer in front of a synchronous-read memory.
// Accepts read/write requests, drives the memory port in the accept cycle,
// absorbs the one-cycle read latency and returns read data in order through
// a two-entry response buffer.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : mem_seq_if.slave (request, response, clear/busy, memory port)
// Build option: define MEM_SEQ_CLEAR_EN to include the zero-fill engine
// (CLEAR state, address counter, busy). Without it, clear is ignored and
// busy is tied low.
module mem_seq #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    mem_seq_if.slave bus
);
    localparam int unsigned OCC_W = 2;
    localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] r_fifo [2];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [OCC_W-1:0]  r_cnt;
    logic              r_inflight;

    logic [OCC_W-1:0]  w_occ;
    logic              w_pop;
    logic              w_push;
    logic              w_room;
    logic              w_accept;
    logic              w_clearing;
    logic [ADDR_W-1:0] w_clr_adr;

    // Occupancy counts the read in flight so the buffer can never overflow.
    assign w_occ  = r_cnt + OCC_W'(r_inflight);
    assign w_pop  = (r_cnt != '0) && bus.rsp_ready;
    assign w_push = r_inflight;
    assign w_room = (w_occ < OCC_W'(2)) || w_pop;

`ifdef MEM_SEQ_CLEAR_EN
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_adr;
    logic              r_busy;

    assign w_clearing    = (r_state == ST_CLEAR);
    assign w_clr_adr     = r_clr_adr;
    assign bus.req_ready = i_rst_n && !w_clearing && !bus.clear && w_room;
    assign bus.busy      = r_busy;

    // Fill starts only once the response path has drained; a started fill
    // always runs to the last address.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_RUN;
            r_clr_adr <= '0;
            r_busy    <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (bus.clear && (w_occ == '0)) begin
                r_state   <= ST_CLEAR;
                r_clr_adr <= '0;
                r_busy    <= 1'b1;
            end
        end else begin
            if (r_clr_adr == LAST_ADR) begin
                r_state   <= ST_RUN;
                r_clr_adr <= '0;
                r_busy    <= 1'b0;
            end else begin
                r_clr_adr <= r_clr_adr + ADDR_W'(1);
            end
        end
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = bus.clear;
    assign w_clearing     = 1'b0;
    assign w_clr_adr      = '0;
    assign bus.req_ready  = i_rst_n && w_room;
    assign bus.busy       = 1'b0;
`endif

    assign w_accept = bus.req_valid && bus.req_ready;

    // Memory port: the fill engine owns it while clearing, otherwise the
    // request passes straight through and is written only when accepted.
    assign bus.mem_adr   = w_clearing ? w_clr_adr : bus.req_adr;
    assign bus.mem_dat_w = w_clearing ? '0 : bus.req_dat;
    assign bus.mem_we    = w_clearing || (w_accept && bus.req_we);

    // Read tracking and two-entry in-order response buffer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept && !bus.req_we;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.mem_dat_r;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + OCC_W'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - OCC_W'(1);
            end
        end
    end

    assign bus.rsp_valid = (r_cnt != '0);
    assign bus.rsp_dat   = r_fifo[r_rd_ptr];

endmodule

// File: doc/mem_seq.md
# mem_seq

Request sequencer sitting directly upstream of the 16x8 synchronous-read memory. Accepts read/write requests on a valid/ready channel, drives the memory's address, write-data and write-enable port, absorbs the memory's one-cycle read latency, and returns read data in order on a valid/ready response channel. The two-entry response buffer gives full throughput under backpressure. An optional clear engine zero-fills the whole memory.

## Interface
- ADDR_W, 4, memory address width; depth = 2**ADDR_W
- DATA_W, 8, memory data width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_adr  in  ADDR_W  request address
- req_dat  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes rsp_dat when rsp_valid && rsp_ready
- rsp_dat  out  DATA_W  read data, issue order
- clear  in  1  level request to zero-fill memory
- busy  out  1  clear engine active
- mem_adr  out  ADDR_W  to memory adr
- mem_dat_w  out  DATA_W  to memory dat_w
- mem_we  out  1  to memory we
- mem_dat_r  in  DATA_W  from memory dat_r; valid the cycle after the read address is presented

## Operation
- States: RUN, CLEAR. Reset → RUN.
- occ = buffered responses + in-flight read (0..2).
- RUN: req_ready = !clear && (occ < 2 || (rsp_valid && rsp_ready)). Writes and reads share this rule; only reads raise occ.
- Accepted request drives the memory port combinationally in the same cycle: mem_adr = req_adr, mem_dat_w = req_dat, mem_we = req_we. No accept → mem_we = 0, mem_adr = req_adr.
- Accepted read sets in-flight. The next cycle mem_dat_r is pushed into the 2-entry FIFO. Responses are strictly in order.
- Read immediately following a write to the same address returns the new data.
- Clear: while clear is high, req_ready is low. Once occ == 0, go to CLEAR. CLEAR writes 0 to addresses 0..2**ADDR_W-1, one per cycle, mem_we = 1, busy = 1. After the last address, return to RUN. Deasserting clear mid-fill does not abort the fill.
- Reset mid-operation: FIFO and in-flight state are discarded, the clear counter returns to 0, and the FSM returns to RUN. Memory contents are untouched.

## Timing
- Reset values: rsp_valid 0, rsp_dat 0, busy 0, mem_we 0; req_ready 0 while rst is low.
- Read latency: accept at edge E → rsp_valid high in the cycle after E+1, i.e. 2 cycles.
- Write: mem_we high exactly in the accept cycle. No response.
- Throughput: with rsp_ready held high, one request per cycle indefinitely.
- req_ready depends combinationally on rsp_ready and clear. No other combinational input-to-output paths except req_* → mem_*.
- FIFO full (2) with no pop: req_ready low. Same-cycle pop and push: occupancy unchanged.
- Clear fill: exactly 2**ADDR_W cycles with busy high. req_ready is low throughout.

## Configuration
- MEM_SEQ_CLEAR_EN defined: CLEAR state, counter and busy logic are present as described above.
- MEM_SEQ_CLEAR_EN undefined: the clear port exists but is ignored. busy is tied 0, the FSM is RUN only, and req_ready omits the !clear term.

## Test plan
- Write 0xA5 to adr 3, then read adr 3 in the next cycle → rsp_valid 2 cycles after read accept, rsp_dat 0xA5. mem_we high exactly 1 cycle.
- Back-to-back reads of adr 0..15 with rsp_ready=1 (memory preloaded with value = 0x10+adr) → 16 responses on consecutive cycles, 0x10..0x1F in order, req_ready never low.
- rsp_ready=0, issue 3 reads → 2 accepted, req_ready low on the third. Raise rsp_ready → third is accepted in the same cycle as the first pop. Order preserved.
- Clear asserted with 2 responses pending (MEM_SEQ_CLEAR_EN) → req_ready low, CLEAR is entered only after both responses are popped. busy is high for 16 cycles, mem_adr steps 0..15 with mem_dat_w 0. Subsequent reads of all addresses return 0x00.
- rst low in the cycle after a read accept → no response appears. After release: rsp_valid 0, req_ready 1, memory data intact.
- MEM_SEQ_CLEAR_EN undefined, clear held high → busy stays 0 and reads and writes proceed normally.
